// File: rtl/aes_inv_round_iter.sv
// Iterative AES-128 inverse-cipher datapath: one inverse round per clock using 11 round keys.
// Optional macro AES_INV_ABORT_EN adds a synchronous abort input.

module inv_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = '0;
        aa = a;
        bb = b;
        for (int unsigned i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (zero maps to zero).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] r;
        sq = x;
        r  = 8'h01;
        for (int unsigned i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    logic [7:0] pre;

    always_comb begin
        pre = {in_byte[6:0], in_byte[7]} ^ {in_byte[4:0], in_byte[7:5]}
            ^ {in_byte[1:0], in_byte[7:2]} ^ 8'h05;
        out_byte = gf_inv(pre);
    end
endmodule

module inv_mix_columns (
    input  logic [127:0] blk,
    output logic [127:0] mixed
);
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        for (int unsigned r = 0; r < 4; r++) begin
            a[r]  = col[31-8*r -: 8];
            x2    = xt(a[r]);
            x4    = xt(x2);
            x8    = xt(x4);
            m9[r] = x8 ^ a[r];
            mb[r] = x8 ^ x2 ^ a[r];
            md[r] = x8 ^ x4 ^ a[r];
            me[r] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    always_comb begin
        mixed = '0;
        for (int unsigned c = 0; c < 4; c++)
            mixed[127-32*c -: 32] = mix_col(blk[127-32*c -: 32]);
    end
endmodule

module aes_inv_round_iter #(
    parameter int unsigned NR     = 10,
    parameter int unsigned KIDX_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [127:0]      in_data,
    output logic [KIDX_W-1:0] key_idx,
    input  logic [127:0]      key_in,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef AES_INV_ABORT_EN
    input  logic              abort,
`endif
    output logic [127:0]      out_data
);
    localparam logic [KIDX_W-1:0] LAST_KEY = KIDX_W'(NR);
    localparam logic [KIDX_W-1:0] LAST_RND = KIDX_W'(NR - 1);

    typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [KIDX_W-1:0] rnd;
    logic [127:0]      blk;
    logic [127:0]      shifted;
    logic [127:0]      subbed;
    logic [127:0]      added;
    logic [127:0]      mixed;
    logic              abort_hit;

`ifdef AES_INV_ABORT_EN
    always_comb abort_hit = abort && (state != S_IDLE);
`else
    always_comb abort_hit = 1'b0;
`endif

    // InvShiftRows: output column c of row r takes input column (c - r) mod 4.
    always_comb begin
        shifted = '0;
        for (int unsigned c = 0; c < 4; c++)
            for (int unsigned r = 0; r < 4; r++)
                shifted[127-8*(4*c+r) -: 8] = blk[127-8*(4*((c+4-r)%4)+r) -: 8];
    end

    for (genvar b = 0; b < 16; b++) begin : g_sbox
        inv_sbox u_inv_sbox (
            .in_byte (shifted[127-8*b -: 8]),
            .out_byte(subbed[127-8*b -: 8])
        );
    end

    always_comb added = subbed ^ key_in;

    inv_mix_columns u_inv_mix_columns (
        .blk  (added),
        .mixed(mixed)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (in_valid) state_nxt = S_ROUND;
            S_ROUND: if (rnd == '0) state_nxt = S_DONE;
            S_DONE:  if (out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (abort_hit) state_nxt = S_IDLE;
    end

    always_comb begin
        in_ready  = (state == S_IDLE);
        out_valid = (state == S_DONE);
        key_idx   = (state == S_IDLE) ? LAST_KEY : rnd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rnd      <= '0;
            blk      <= '0;
            out_data <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        blk <= in_data ^ key_in;
                        rnd <= LAST_RND;
                    end
                end
                S_ROUND: begin
                    if (!abort_hit) begin
                        if (rnd != '0) begin
                            blk <= mixed;
                            rnd <= rnd - KIDX_W'(1);
                        end else begin
                            out_data <= added;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
